// File: rtl/vga_timing_grid_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_grid_if
// Description : Video timing bundle produced by vga_timing_grid. It carries
//               the pixel strobe, the sync pulses, the active-area coordinates
//               and the cell position of the current pixel within the grid.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_grid_if;
    logic        pix_ce;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic [11:0] x;
    logic [11:0] y;
    logic        line_tick;
    logic        frame_tick;
    logic [15:0] frame_cnt;
    logic        in_grid;
    logic [5:0]  cell_col;
    logic [5:0]  cell_row;

    modport master (
        output pix_ce, hsync, vsync, active, x, y,
        output line_tick, frame_tick, frame_cnt, in_grid, cell_col, cell_row
    );

    modport slave (
        input  pix_ce, hsync, vsync, active, x, y,
        input  line_tick, frame_tick, frame_cnt, in_grid, cell_col, cell_row
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_grid.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_grid
// Description : Raster timing generator with a pixel-clock divider and a
//               rectangular cell grid overlay. Every output is registered and
//               describes the same pixel; cell indices come from running
//               sub-cell counters rather than division.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_grid #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int PIX_DIV   = 2,
    parameter int GRID_X0   = 235,
    parameter int GRID_Y0   = 10,
    parameter int CELL_W    = 19,
    parameter int CELL_H    = 23,
    parameter int GRID_COLS = 10,
    parameter int GRID_ROWS = 20
) (
    input  wire logic           CLOCK_50,
    input  wire logic           RESET_N,
    vga_timing_grid_if.master   o_vid
);

    localparam int          c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] c_H_LAST   = 12'(c_H_TOTAL - 1);
    localparam logic [11:0] c_V_LAST   = 12'(c_V_TOTAL - 1);
    localparam logic [11:0] c_H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] c_V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] c_HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]  c_DIV_LAST = 4'(PIX_DIV - 1);
    localparam logic [11:0] c_GX0      = 12'(GRID_X0);
    localparam logic [11:0] c_GY0      = 12'(GRID_Y0);
    localparam logic [11:0] c_CW_LAST  = 12'(CELL_W - 1);
    localparam logic [11:0] c_CH_LAST  = 12'(CELL_H - 1);
    localparam logic [5:0]  c_COL_LAST = 6'(GRID_COLS - 1);
    localparam logic [5:0]  c_ROW_LAST = 6'(GRID_ROWS - 1);
    // A grid anchored at coordinate 0 is already entered on the reset pixel.
    localparam bit          c_GX_AT0   = (GRID_X0 == 0);
    localparam bit          c_GY_AT0   = (GRID_Y0 == 0);

    // Raster position of the pixel that the next strobe will present.
    logic [3:0]  r_div;
    logic [11:0] r_h;
    logic [11:0] r_v;
    logic [15:0] r_frames;

    // Sub-cell trackers kept in step with r_h / r_v.
    logic [11:0] r_gx_sub;
    logic [5:0]  r_gx_col;
    logic        r_gx_in;
    logic [11:0] r_gy_sub;
    logic [5:0]  r_gy_row;
    logic        r_gy_in;

    // Registered outputs.
    logic        r_pix_ce;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_active;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic        r_line_tick;
    logic        r_frame_tick;
    logic [15:0] r_frame_cnt;
    logic        r_in_grid;
    logic [5:0]  r_cell_col;
    logic [5:0]  r_cell_row;

    logic [3:0]  w_div_next;
    logic        w_load;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic [11:0] w_h_next;
    logic [11:0] w_v_next;
    logic        w_active;
    logic        w_in_grid;

    // A pixel is presented in the cycle the divider reaches its last count,
    // so the outputs load on the edge that moves the divider there.
    assign w_div_next = (r_div == c_DIV_LAST) ? 4'd0 : r_div + 4'd1;
    assign w_load     = (w_div_next == c_DIV_LAST);
    assign w_h_wrap   = (r_h == c_H_LAST);
    assign w_v_wrap   = (r_v == c_V_LAST);
    assign w_h_next   = w_h_wrap ? 12'd0 : r_h + 12'd1;
    assign w_v_next   = w_v_wrap ? 12'd0 : r_v + 12'd1;
    assign w_active   = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign w_in_grid  = w_active && r_gx_in && r_gy_in;

    // Pixel-clock divider.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_div <= 4'd0;
        end else begin
            r_div <= w_div_next;
        end
    end

    // Horizontal / vertical position and completed-frame count.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_h      <= 12'd0;
            r_v      <= 12'd0;
            r_frames <= 16'd0;
        end else if (w_load) begin
            r_h <= w_h_next;
            if (w_h_wrap) begin
                r_v <= w_v_next;
                if (w_v_wrap) begin
                    r_frames <= r_frames + 16'd1;
                end
            end
        end
    end

    // Column tracker: restarts at the grid origin, steps a column every CELL_W pixels.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_gx_sub <= 12'd0;
            r_gx_col <= 6'd0;
            r_gx_in  <= c_GX_AT0;
        end else if (w_load) begin
            if (w_h_next == c_GX0) begin
                r_gx_sub <= 12'd0;
                r_gx_col <= 6'd0;
                r_gx_in  <= 1'b1;
            end else if (r_gx_in) begin
                if (r_gx_sub == c_CW_LAST) begin
                    r_gx_sub <= 12'd0;
                    if (r_gx_col == c_COL_LAST) begin
                        r_gx_in <= 1'b0;
                    end else begin
                        r_gx_col <= r_gx_col + 6'd1;
                    end
                end else begin
                    r_gx_sub <= r_gx_sub + 12'd1;
                end
            end
        end
    end

    // Row tracker: same scheme as the columns, advanced once per line.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_gy_sub <= 12'd0;
            r_gy_row <= 6'd0;
            r_gy_in  <= c_GY_AT0;
        end else if (w_load && w_h_wrap) begin
            if (w_v_next == c_GY0) begin
                r_gy_sub <= 12'd0;
                r_gy_row <= 6'd0;
                r_gy_in  <= 1'b1;
            end else if (r_gy_in) begin
                if (r_gy_sub == c_CH_LAST) begin
                    r_gy_sub <= 12'd0;
                    if (r_gy_row == c_ROW_LAST) begin
                        r_gy_in <= 1'b0;
                    end else begin
                        r_gy_row <= r_gy_row + 6'd1;
                    end
                end else begin
                    r_gy_sub <= r_gy_sub + 12'd1;
                end
            end
        end
    end

    // Output register: everything describes pixel (r_h, r_v) at the same time.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_pix_ce     <= 1'b0;
            r_hsync      <= ~HS_POL;
            r_vsync      <= ~VS_POL;
            r_active     <= 1'b0;
            r_x          <= 12'd0;
            r_y          <= 12'd0;
            r_line_tick  <= 1'b0;
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= 16'd0;
            r_in_grid    <= 1'b0;
            r_cell_col   <= 6'd0;
            r_cell_row   <= 6'd0;
        end else begin
            r_pix_ce <= w_load;
            if (w_load) begin
                r_hsync      <= ((r_h >= c_HS_START) && (r_h < c_HS_END)) ? HS_POL : ~HS_POL;
                r_vsync      <= ((r_v >= c_VS_START) && (r_v < c_VS_END)) ? VS_POL : ~VS_POL;
                r_active     <= w_active;
                r_x          <= w_active ? r_h : 12'd0;
                r_y          <= w_active ? r_v : 12'd0;
                r_line_tick  <= (r_h == 12'd0);
                r_frame_tick <= (r_h == 12'd0) && (r_v == 12'd0);
                r_frame_cnt  <= r_frames;
                r_in_grid    <= w_in_grid;
                r_cell_col   <= w_in_grid ? r_gx_col : 6'd0;
                r_cell_row   <= w_in_grid ? r_gy_row : 6'd0;
            end
        end
    end

    assign o_vid.pix_ce     = r_pix_ce;
    assign o_vid.hsync      = r_hsync;
    assign o_vid.vsync      = r_vsync;
    assign o_vid.active     = r_active;
    assign o_vid.x          = r_x;
    assign o_vid.y          = r_y;
    assign o_vid.line_tick  = r_line_tick;
    assign o_vid.frame_tick = r_frame_tick;
    assign o_vid.frame_cnt  = r_frame_cnt;
    assign o_vid.in_grid    = r_in_grid;
    assign o_vid.cell_col   = r_cell_col;
    assign o_vid.cell_row   = r_cell_row;

endmodule
`default_nettype wire
